// File: rtl/conv_skew_feeder.sv
// Purpose: re-times one PE_SIZE-lane word per cycle into the diagonal (skewed) wavefront of the PE array.
// Latency: lane i appears i+1 cycles after acceptance; done pulses with the last lane of the last word.
// Backpressure: en=0 freezes everything; in_ready drops while a tile drains or while reset is asserted.
module conv_skew_feeder #(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [PE_SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [PE_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [PE_SIZE-1:0]            out_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = $clog2(PE_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            accept;

    // Ready is held low during reset so nothing looks acceptable while the block clears.
    assign in_ready = rst_n & en & (state_q != DRAIN);
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    // One shift register per lane, lane i being i+1 stages deep; bubbles carry zero data.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [0:i];
        logic                  vld_q [0:i];

        // Shift the lane forward on every enabled cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    dat_q[s] <= '0;
                    vld_q[s] <= 1'b0;
                end
            end else if (en) begin
                dat_q[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                vld_q[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    dat_q[s] <= dat_q[s-1];
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
        assign out_valid[i]                         = vld_q[i];
    end

    // Tile tracking: the drain counter covers the PE_SIZE-1 cycles the last word needs to reach the top lane.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (PE_SIZE == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = CW'(PE_SIZE - 1);
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers advance only on enabled cycles, so a stall also holds the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_skew_feeder.sv
// Purpose: self-checking bench for conv_skew_feeder (directed tile scenarios plus randomized traffic).
// Latency: outputs are compared every cycle on the falling edge against a word-history model.
// Backpressure: en, in_valid, in_last and reset are exercised, including stalls and mid-tile aborts.
module tb_conv_skew_feeder;

    localparam int P = 16;
    localparam int W = 8;
    localparam int N = 8192;

    logic           clk = 1'b0;
    logic           rst_n, en, in_valid, in_last;
    logic [P*W-1:0] in_data;
    logic           in_ready, busy, done;
    logic [P*W-1:0] out_data;
    logic [P-1:0]   out_valid;

    int checks   = 0;
    int failures = 0;

    conv_skew_feeder #(.PE_SIZE(P), .DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Model: T counts enabled advances; the word accepted on advance t shows on lane i when T == t+i.
    int             T = 0;
    int             floor_t = 1;
    int             L = 0;
    bit             have_last = 0;
    bit             in_tile = 0;
    bit             done_e = 0;
    bit             live = 0;
    bit             m_acc;
    bit             acc_v [N];
    logic [P*W-1:0] acc_d [N];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge from the bench's own view of the inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            live      = 1;
            floor_t   = T + 1;
            have_last = 0;
            in_tile   = 0;
            done_e    = 0;
        end else if (en) begin
            m_acc = in_valid && !have_last;
            T++;
            acc_v[T] = m_acc;
            acc_d[T] = in_data;
            done_e   = 0;
            if (m_acc) begin
                in_tile = 1;
                if (in_last) begin
                    have_last = 1;
                    L         = T;
                end
            end
            if (have_last && T == L + P - 1) begin
                done_e    = 1;
                have_last = 0;
                in_tile   = 0;
            end
        end
    end

    // Compare every cycle once the first reset edge has been seen.
    always @(negedge clk) begin
        logic [P*W-1:0] ed;
        logic [P-1:0]   ev;
        int             ix;
        if (live) begin
            ed = '0;
            ev = '0;
            for (int i = 0; i < P; i++) begin
                ix = T - i;
                if (ix >= floor_t && ix >= 1 && acc_v[ix]) begin
                    ev[i]        = 1'b1;
                    ed[i*W +: W] = acc_d[ix][i*W +: W];
                end
            end
            chk("m_out_valid", out_valid, ev);
            chk("m_out_data", out_data, ed);
            chk("m_busy", busy, in_tile);
            chk("m_done", done, done_e);
            chk("m_in_ready", in_ready, rst_n && en && !have_last);
        end
    end

    task automatic set_in(input bit r, input bit e, input bit v, input bit l, input logic [P*W-1:0] d);
        rst_n    = r;
        en       = e;
        in_valid = v;
        in_last  = l;
        in_data  = d;
    endtask

    // Advance n rising edges and land on the following falling edge.
    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic single_word(input string tag);
        logic [P*W-1:0] w;
        logic [P*W-1:0] e;
        for (int i = 0; i < P; i++) w[i*W +: W] = W'(i + 1);
        @(posedge clk); #1;
        set_in(1, 1, 1, 1, w);
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        chk({tag, "_v0"}, out_valid, 16'h0001);
        e = '0; e[0 +: W] = 8'd1;
        chk({tag, "_d0"}, out_data, e);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_rdy_drain"}, in_ready, 1'b0);
        after_edges(5);
        chk({tag, "_v5"}, out_valid, 16'h0020);
        e = '0; e[5*W +: W] = 8'd6;
        chk({tag, "_d5"}, out_data, e);
        after_edges(9);
        chk({tag, "_done14"}, done, 1'b0);
        after_edges(1);
        chk({tag, "_done15"}, done, 1'b1);
        chk({tag, "_v15"}, out_valid, 16'h8000);
        e = '0; e[15*W +: W] = 8'd16;
        chk({tag, "_d15"}, out_data, e);
        after_edges(1);
        chk({tag, "_done16"}, done, 1'b0);
        chk({tag, "_busy16"}, busy, 1'b0);
        chk({tag, "_rdy16"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [P*W-1:0] w;

        // Reset held with valid input present.
        set_in(0, 1, 1, 1, '1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", out_valid, '0);
        chk("rst_data", out_data, '0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_busy", busy, 1'b0);

        single_word("sw");

        // Burst of four words, last on the fourth.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < P; i++) w[i*W +: W] = W'(16 * k + i);
            @(posedge clk); #1;
            set_in(1, 1, 1, k == 3, w);
        end
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        after_edges(14);
        chk("burst_done17", done, 1'b0);
        chk("burst_rdy17", in_ready, 1'b0);
        after_edges(1);
        chk("burst_done18", done, 1'b1);

        // Bubble between two words.
        @(posedge clk); #1;
        set_in(1, 1, 1, 0, {P{8'hAA}});
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(posedge clk); #1;
        set_in(1, 1, 1, 1, {P{8'hBB}});
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        after_edges(14);
        chk("bub_done16", done, 1'b0);
        after_edges(1);
        chk("bub_done17", done, 1'b1);

        // Stall for three edges mid-drain.
        for (int i = 0; i < P; i++) w[i*W +: W] = W'(8'h40 + i);
        @(posedge clk); #1;
        set_in(1, 1, 1, 1, w);
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        repeat (5) @(posedge clk);
        #1;
        set_in(1, 0, 0, 0, '0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_valid", out_valid, 16'h0020);
        chk("stall_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        after_edges(9);
        chk("stall_done17", done, 1'b0);
        after_edges(1);
        chk("stall_done18", done, 1'b1);

        // Abort a drain with reset, then repeat the single-word tile.
        @(posedge clk); #1;
        set_in(1, 1, 1, 1, w);
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        repeat (4) @(posedge clk);
        #1;
        set_in(0, 1, 0, 0, '0);
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        @(negedge clk);
        chk("abort_valid", out_valid, '0);
        chk("abort_data", out_data, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        after_edges(20);
        single_word("sw2");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            set_in($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                   {$urandom, $urandom, $urandom, $urandom});
        end
        @(posedge clk); #1;
        set_in(1, 1, 0, 0, '0);
        after_edges(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
